// File: rtl/tx_queue_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tx_queue_sched_pkg
// Description : Shared constants for the tx queue scheduler. It holds the
//               queue count, the default field widths and the FSM state
//               encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package tx_queue_sched_pkg;

    // The scheduler and its picker are built for exactly four queues.
    localparam int NUM_Q            = 4;
    localparam int CW_EXP_WIDTH_DEF = 4;
    localparam int RETRY_WIDTH_DEF  = 4;

    // These are the sched_state encodings. Code 3 is unused and falls back
    // to IDLE.
    localparam logic [1:0] SCHED_IDLE   = 2'd0;
    localparam logic [1:0] SCHED_TX     = 2'd1;
    localparam logic [1:0] SCHED_RESULT = 2'd2;

endpackage : tx_queue_sched_pkg
`default_nettype wire

// File: rtl/tx_queue_sched_rr_pick4.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick4
// Description : Combinational 4-way round-robin priority picker. It returns
//               the first set bit of elig, searching from rr_ptr upward
//               modulo 4.
// Ports       : elig   - eligible request vector
//               rr_ptr - highest-priority position
//               valid  - at least one request is eligible
//               idx    - index of the winning request
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4 (
    input  wire logic [3:0] elig,
    input  wire logic [1:0] rr_ptr,
    output logic            valid,
    output logic [1:0]      idx
);

    logic [1:0] w_pos;

    // The loop scans from the farthest offset down to offset 0. The nearest
    // set bit after rr_ptr is therefore the last one written.
    always_comb begin
        valid = 1'b0;
        idx   = 2'd0;
        w_pos = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            w_pos = rr_ptr + 2'(i);
            if (elig[w_pos]) begin
                valid = 1'b1;
                idx   = w_pos;
            end
        end
    end

endmodule : rr_pick4
`default_nettype wire

// File: rtl/tx_queue_sched.sv
`default_nettype none
// ============================================================================
// Module      : tx_queue_sched
// Description : Round-robin scheduler for four tx queues that share one
//               CSMA/CA backoff engine. It launches one transmission per
//               backoff expiry and waits for the ack result or an ack
//               timeout. It then applies the binary-exponential CW update,
//               the retry count and the drop policy.
// Ports       : clk, rst (sync, active high), tsf_pulse_1M (1 us tick)
//               queue_req/slice_en   - per-queue eligibility inputs
//               backoff_done         - backoff expired, medium free
//               cw_min_exp/cw_max_exp, retry_limit, tx_timeout_top - config
//               tx_end_strobe/tx_ack_ok - tx result
//               cw_exp               - CW exponent of the current candidate
//               tx_start/tx_q_idx/tx_busy - launch pulse, queue, busy flag
//               drop_strobe/drop_q_idx    - frame discard pulse and queue
//               sched_state          - FSM state readback
// Revision    : 1.0 - initial release
// ============================================================================
module tx_queue_sched
    import tx_queue_sched_pkg::*;
#(
    parameter int CW_EXP_WIDTH  = CW_EXP_WIDTH_DEF,
    parameter int RETRY_WIDTH   = RETRY_WIDTH_DEF,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     tsf_pulse_1M,
    input  wire logic [NUM_Q-1:0]         queue_req,
    input  wire logic [NUM_Q-1:0]         slice_en,
    input  wire logic                     backoff_done,
    input  wire logic [CW_EXP_WIDTH-1:0]  cw_min_exp,
    input  wire logic [CW_EXP_WIDTH-1:0]  cw_max_exp,
    input  wire logic [RETRY_WIDTH-1:0]   retry_limit,
    input  wire logic [TIMEOUT_WIDTH-1:0] tx_timeout_top,
    input  wire logic                     tx_end_strobe,
    input  wire logic                     tx_ack_ok,
    output logic [CW_EXP_WIDTH-1:0]       cw_exp,
    output logic                          tx_start,
    output logic [1:0]                    tx_q_idx,
    output logic                          tx_busy,
    output logic                          drop_strobe,
    output logic [1:0]                    drop_q_idx,
    output logic [1:0]                    sched_state
);

    logic [CW_EXP_WIDTH-1:0]  r_cw    [NUM_Q];
    logic [RETRY_WIDTH-1:0]   r_retry [NUM_Q];
    logic [1:0]               r_state;
    logic [1:0]               r_rr_ptr;
    logic [1:0]               r_tx_q;
    logic [1:0]               r_drop_q;
    logic [TIMEOUT_WIDTH-1:0] r_tmo_cnt;
    logic                     r_ok;
    logic                     r_tx_start;
    logic                     r_tx_busy;
    logic                     r_drop;
    logic [CW_EXP_WIDTH-1:0]  r_cw_exp;

    logic [NUM_Q-1:0]         w_elig;
    logic                     w_cand_vld;
    logic [1:0]               w_cand_idx;
    logic [TIMEOUT_WIDTH:0]   w_tmo_inc;
    logic [CW_EXP_WIDTH:0]    w_cw_inc;
    logic [CW_EXP_WIDTH-1:0]  w_cw_bumped;
    logic [CW_EXP_WIDTH-1:0]  w_cw_floor;
    logic [RETRY_WIDTH:0]     w_retry_inc;
    logic                     w_drop;
    logic [1:0]               w_rr_next;

    assign w_elig = queue_req & slice_en;

    rr_pick4 u_pick (
        .elig   (w_elig),
        .rr_ptr (r_rr_ptr),
        .valid  (w_cand_vld),
        .idx    (w_cand_idx)
    );

    // The increments are one bit wider so that overflow and saturation can
    // be detected. The CW reset value is also clamped to the ceiling, which
    // covers a misconfiguration where min exceeds max.
    assign w_tmo_inc   = {1'b0, r_tmo_cnt} + 1'b1;
    assign w_cw_inc    = {1'b0, r_cw[r_tx_q]} + 1'b1;
    assign w_cw_bumped = (w_cw_inc > {1'b0, cw_max_exp}) ? cw_max_exp
                                                         : w_cw_inc[CW_EXP_WIDTH-1:0];
    assign w_cw_floor  = (cw_min_exp > cw_max_exp) ? cw_max_exp : cw_min_exp;
    assign w_retry_inc = {1'b0, r_retry[r_tx_q]} + 1'b1;
    assign w_drop      = w_retry_inc > {1'b0, retry_limit};
    assign w_rr_next   = r_tx_q + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_Q; i++) begin
                r_cw[i]    <= cw_min_exp;
                r_retry[i] <= '0;
            end
            r_state    <= SCHED_IDLE;
            r_rr_ptr   <= 2'd0;
            r_tx_q     <= 2'd0;
            r_drop_q   <= 2'd0;
            r_tmo_cnt  <= '0;
            r_ok       <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_busy  <= 1'b0;
            r_drop     <= 1'b0;
            r_cw_exp   <= cw_min_exp;
        end else begin
            r_tx_start <= 1'b0;
            r_drop     <= 1'b0;

            // cw_exp follows the candidate and holds its last value when no
            // queue is eligible.
            if (w_cand_vld) begin
                r_cw_exp <= r_cw[w_cand_idx];
            end

            case (r_state)
                SCHED_IDLE: begin
                    if (backoff_done && w_cand_vld) begin
                        r_tx_start <= 1'b1;
                        r_tx_q     <= w_cand_idx;
                        r_tmo_cnt  <= '0;
                        r_tx_busy  <= 1'b1;
                        r_state    <= SCHED_TX;
                    end
                end

                SCHED_TX: begin
                    if (tsf_pulse_1M && !w_tmo_inc[TIMEOUT_WIDTH]) begin
                        r_tmo_cnt <= w_tmo_inc[TIMEOUT_WIDTH-1:0];
                    end
                    // A real result takes priority over a timeout that
                    // expires in the same cycle.
                    if (tx_end_strobe) begin
                        r_ok    <= tx_ack_ok;
                        r_state <= SCHED_RESULT;
                    end else if (r_tmo_cnt > tx_timeout_top) begin
                        r_ok    <= 1'b0;
                        r_state <= SCHED_RESULT;
                    end
                end

                SCHED_RESULT: begin
                    r_state   <= SCHED_IDLE;
                    r_tx_busy <= 1'b0;
                    if (r_ok) begin
                        r_cw[r_tx_q]    <= w_cw_floor;
                        r_retry[r_tx_q] <= '0;
                        r_rr_ptr        <= w_rr_next;
                    end else if (w_drop) begin
                        r_drop          <= 1'b1;
                        r_drop_q        <= r_tx_q;
                        r_cw[r_tx_q]    <= w_cw_floor;
                        r_retry[r_tx_q] <= '0;
                        r_rr_ptr        <= w_rr_next;
                    end else begin
                        // rr_ptr is left unchanged so the retried queue keeps
                        // first priority.
                        r_retry[r_tx_q] <= w_retry_inc[RETRY_WIDTH-1:0];
                        r_cw[r_tx_q]    <= w_cw_bumped;
                    end
                end

                default: begin
                    r_state   <= SCHED_IDLE;
                    r_tx_busy <= 1'b0;
                end
            endcase
        end
    end

    assign cw_exp      = r_cw_exp;
    assign tx_start    = r_tx_start;
    assign tx_q_idx    = r_tx_q;
    assign tx_busy     = r_tx_busy;
    assign drop_strobe = r_drop;
    assign drop_q_idx  = r_drop_q;
    assign sched_state = r_state;

endmodule : tx_queue_sched
`default_nettype wire
